// File: rtl/ppm_tx_pkg.sv
// Shared types and default constants for the PPM transmit scheduler.
package ppm_tx_pkg;

    localparam int LEN_W  = 4;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 8;

    localparam int DEF_MAX_LEN        = 15;
    localparam int DEF_SETTLE_CYCLES  = 3;
    localparam int DEF_GUARD_CYCLES   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        LOAD_HDR,
        LOAD_DATA,
        SETTLE,
        TRIGGER,
        WAIT_DONE,
        GUARD
    } state_e;

endpackage

// File: rtl/ppm_tx_stage_mem.sv
// Frame staging register file: written byte by byte while collecting,
// read combinationally while replaying into the frame buffer.
module ppm_tx_stage_mem
    import ppm_tx_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [LEN_W-1:0]  waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [LEN_W-1:0]  raddr_i,
    output logic [BYTE_W-1:0] rdata_o
);

    logic [BYTE_W-1:0] mem_q [1<<LEN_W];

    // Write port; contents need no reset since every byte is written before it is read.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ppm_tx_scheduler.sv
// PPM transmit scheduler: collects a host frame, replays it into the frame
// buffer load port, triggers transmission and waits for completion.
module ppm_tx_scheduler
    import ppm_tx_pkg::*;
#(
    parameter int MAX_LEN        = DEF_MAX_LEN,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_start,
    input  logic [LEN_W-1:0]  host_len,
    input  logic [BYTE_W-1:0] host_data,
    input  logic              host_valid,
    output logic              host_ready,
    output logic              busy,
    output logic              tx_done,
    output logic              tx_err,
    output logic              buf_le,
    output logic [LEN_W-1:0]  buf_n,
    output logic [BYTE_W-1:0] buf_din,
    output logic              buf_start_trans,
    input  logic              buf_frame_done
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              done_d, err_d;
    logic              host_ready_q, busy_q, tx_done_q, tx_err_q;
    logic              buf_le_q, buf_st_q;
    logic [LEN_W-1:0]  buf_n_q;
    logic [BYTE_W-1:0] buf_din_q;
    logic [BYTE_W-1:0] stage_rd;
    logic              hs;

    assign hs = (state_q == COLLECT) && host_valid && host_ready_q;

    // Read address follows the next index so the registered Din lines up with its cycle.
    ppm_tx_stage_mem u_stage (
        .clk     (clk),
        .we_i    (hs),
        .waddr_i (idx_q),
        .wdata_i (host_data),
        .raddr_i (idx_d),
        .rdata_o (stage_rd)
    );

    // Next-state, index and counter sequencing.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (host_start) begin
                    if (host_len == '0 || int'(host_len) > MAX_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = host_len;
                        idx_d   = '0;
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (hs) begin
                    if (idx_q == len_q - LEN_W'(1)) begin
                        idx_d   = '0;
                        state_d = LOAD_HDR;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            LOAD_HDR: begin
                idx_d   = '0;
                state_d = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (idx_q == len_q - LEN_W'(1)) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = TRIGGER;
                else                                     cnt_d   = cnt_q + CNT_W'(1);
            end
            TRIGGER: begin
                tcnt_d  = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // frame_done is checked first so it wins over a simultaneous timeout
                if (buf_frame_done) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GUARD;
                end else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = GUARD;
                end else if (tcnt_q != {TO_W{1'b1}}) begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            GUARD: begin
                if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) state_d = IDLE;
                else                                    cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            host_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_err_q     <= 1'b0;
            buf_le_q     <= 1'b0;
            buf_n_q      <= '0;
            buf_din_q    <= '0;
            buf_st_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            host_ready_q <= (state_d == COLLECT);
            busy_q       <= (state_d != IDLE);
            tx_done_q    <= done_d;
            tx_err_q     <= err_d;
            buf_le_q     <= (state_d == LOAD_HDR);
            buf_n_q      <= (state_d == LOAD_HDR) ? len_d : '0;
            buf_din_q    <= (state_d == LOAD_DATA) ? stage_rd : '0;
            buf_st_q     <= (state_d == TRIGGER);
        end
    end

    assign host_ready      = host_ready_q;
    assign busy            = busy_q;
    assign tx_done         = tx_done_q;
    assign tx_err          = tx_err_q;
    assign buf_le          = buf_le_q;
    assign buf_n           = buf_n_q;
    assign buf_din         = buf_din_q;
    assign buf_start_trans = buf_st_q;

endmodule

// File: tb/tb_ppm_tx_scheduler.sv
// Directed bench for ppm_tx_scheduler with a short timeout.
module tb_ppm_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_start = 1'b0;
    logic [3:0] host_len = '0;
    logic [7:0] host_data = '0;
    logic       host_valid = 1'b0;
    logic       host_ready, busy, tx_done, tx_err;
    logic       buf_le, buf_start_trans;
    logic [3:0] buf_n;
    logic [7:0] buf_din;
    logic       buf_frame_done = 1'b0;

    int nerr = 0;
    int nchk = 0;
    logic [7:0] fb [16];

    ppm_tx_scheduler #(
        .MAX_LEN(15), .SETTLE_CYCLES(3), .GUARD_CYCLES(4), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .rst(rst),
        .host_start(host_start), .host_len(host_len),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
        .busy(busy), .tx_done(tx_done), .tx_err(tx_err),
        .buf_le(buf_le), .buf_n(buf_n), .buf_din(buf_din),
        .buf_start_trans(buf_start_trans), .buf_frame_done(buf_frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk(tag, {host_ready, busy, tx_done, tx_err, buf_le, buf_n, buf_din, buf_start_trans}, 32'h0);
    endtask

    // Start a frame and hand over its bytes; ends in the cycle after the last handshake.
    task automatic do_frame(input int len, input int stall_at, input int stall_n);
        host_start = 1'b1; host_len = 4'(len);
        tick();
        host_start = 1'b0;
        chk("collect_ready", {host_ready, busy}, 32'h3);
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                host_valid = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    chk("stall_hold", {host_ready, buf_le}, 32'h2);
                end
            end
            host_valid = 1'b1; host_data = fb[i];
            tick();
        end
        host_valid = 1'b0; host_data = 8'h00;
    endtask

    // Check header, data, settle and trigger; ends in the TRIGGER cycle.
    task automatic chk_load(input int len, input bit inject);
        chk("hdr", {host_ready, buf_le, buf_n, buf_din}, {19'h0, 1'b0, 1'b1, 4'(len), 8'h00});
        for (int i = 0; i < len; i++) begin
            if (inject && i == 5) begin host_start = 1'b1; host_len = 4'd3; end
            tick();
            host_start = 1'b0;
            chk("din", {buf_le, buf_n, buf_din, buf_start_trans}, {18'h0, 1'b0, 4'h0, fb[i], 1'b0});
        end
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("settle", {buf_le, buf_din, buf_start_trans}, 32'h0);
        end
        tick();
        chk("trigger", {buf_start_trans, buf_le, busy}, 32'h5);
    endtask

    // From TRIGGER: wait wait_n WAIT_DONE cycles, deliver frame_done, check guard.
    task automatic finish_done(input int wait_n, input bit hold2);
        tick();
        chk("trig_drop", buf_start_trans, 32'h0);
        for (int w = 0; w < wait_n; w++) tick();
        buf_frame_done = 1'b1;
        tick();
        chk("done_pulse", {tx_done, tx_err, busy}, 32'h5);
        buf_frame_done = hold2;
        tick();
        buf_frame_done = 1'b0;
        chk("guard1", {tx_done, tx_err, busy}, 32'h1);
        tick();
        tick();
        chk("guard3", busy, 32'h1);
        tick();
        chk("guard_exit", {busy, tx_done, tx_err}, 32'h0);
    endtask

    initial begin
        // reset
        tick(); tick();
        chk_idle_outs("reset");
        rst = 1'b0;
        tick();
        chk_idle_outs("post_reset");

        // nominal 4-byte frame; frame_done held into guard must not re-pulse tx_done
        fb[0] = 8'hC0; fb[1] = 8'hAA; fb[2] = 8'hDD; fb[3] = 8'hAE;
        do_frame(4, -1, 0);
        chk_load(4, 1'b0);
        finish_done(2, 1'b1);

        // host stall of 5 cycles between AA and DD; frame_done on the last timeout cycle
        do_frame(4, 2, 5);
        chk_load(4, 1'b0);
        finish_done(19, 1'b0);

        // bad length
        host_start = 1'b1; host_len = 4'd0;
        tick();
        host_start = 1'b0;
        chk("badlen_err", {tx_err, busy, host_ready, buf_le}, 32'h8);
        tick();
        chk_idle_outs("badlen_after");

        // max length with an ignored request during load, then timeout
        for (int i = 0; i < 15; i++) fb[i] = 8'(i + 1);
        do_frame(15, -1, 0);
        chk_load(15, 1'b1);
        tick();
        for (int w = 0; w < 19; w++) begin
            tick();
            chk("to_wait", {tx_err, tx_done, buf_le, host_ready, busy}, 32'h1);
        end
        tick();
        chk("to_err", {tx_err, tx_done, busy}, 32'h5);
        tick();
        chk("to_err_drop", {tx_err, busy}, 32'h1);
        tick(); tick();
        chk("to_guard3", busy, 32'h1);
        tick();
        chk_idle_outs("to_idle");

        // reset during the 2nd LOAD_DATA cycle
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
        do_frame(4, -1, 0);
        tick();
        chk("rst_ld1", buf_din, 32'h11);
        tick();
        chk("rst_ld2", buf_din, 32'h22);
        rst = 1'b1;
        tick();
        chk_idle_outs("rst_mid");
        rst = 1'b0;
        tick();
        chk_idle_outs("rst_mid_after");

        // single-byte frame after reset
        fb[0] = 8'h5A;
        do_frame(1, -1, 0);
        chk_load(1, 1'b0);
        finish_done(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ppm_tx_scheduler.md
Name: ppm_tx_scheduler

Overview:
Sequences the PPM transmit path by driving the frame buffer's load port and its start-trans trigger.
- Collects a frame of 1..15 bytes from a host valid/ready stream into local staging.
- Replays the frame into the frame buffer back-to-back: one header cycle with Le/N, then N consecutive Din cycles.
- Waits a settle gap, pulses start_trans, then waits for frame_done with a timeout.
- Reports done/error to the host and enforces an inter-frame guard time.

Parameters:
MAX_LEN, 15, maximum frame length in bytes; must fit the 4-bit N field.
SETTLE_CYCLES, 3, idle cycles between the last Din and the start_trans pulse (range 1..15).
GUARD_CYCLES, 4, idle cycles after frame_done before a new host_start is accepted.
TIMEOUT_CYCLES, 65535, maximum cycles in WAIT_DONE before an error is declared.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
host_start  in  1  single-cycle request; samples host_len.
host_len  in  4  frame length in bytes; valid when host_start=1.
host_data  in  8  frame byte.
host_valid  in  1  host_data valid.
host_ready  out  1  byte accepted when host_valid && host_ready.
busy  out  1  high in every state except IDLE.
tx_done  out  1  one-cycle pulse: frame_done received.
tx_err  out  1  one-cycle pulse: bad length or timeout.
buf_le  out  1  frame buffer Le.
buf_n  out  4  frame buffer N.
buf_din  out  8  frame buffer Din.
buf_start_trans  out  1  frame buffer start_trans.
buf_frame_done  in  1  frame buffer frame_done.

Behaviour:
- Reset values: all outputs 0 (host_ready=0, busy=0, buf_*=0, tx_done=0, tx_err=0); state=IDLE; len, index and counters cleared.
- Reset asserted in any state returns to IDLE on the next edge. The partial frame is discarded and all buffer outputs drop to 0 that same edge.
- All outputs are registered.
- IDLE:
  - host_start with host_len in 1..MAX_LEN: latch len, clear idx, go to COLLECT.
  - host_start with host_len=0: tx_err pulse next cycle, stay in IDLE.
- COLLECT:
  - host_ready=1.
  - Each handshake writes stage[idx] and increments idx.
  - When the handshake with idx==len-1 occurs: host_ready drops the next cycle, go to LOAD_HDR.
  - Host stalls (host_valid=0) are allowed indefinitely.
- LOAD_HDR: exactly 1 cycle, buf_le=1, buf_n=len, buf_din=0.
- LOAD_DATA:
  - Exactly len consecutive cycles, buf_le=0, buf_n=0, buf_din=stage[i] for i=0..len-1.
  - No gaps permitted.
- SETTLE: SETTLE_CYCLES cycles, buf_din=0.
- TRIGGER: exactly 1 cycle, buf_start_trans=1.
- WAIT_DONE:
  - Timeout counter starts at 0.
  - buf_frame_done=1: tx_done pulse, go to GUARD.
  - Counter reaching TIMEOUT_CYCLES-1 without frame_done: tx_err pulse, go to GUARD.
  - frame_done and timeout in the same cycle: done wins (tx_done, no tx_err).
- GUARD:
  - GUARD_CYCLES cycles, then IDLE.
  - buf_frame_done arriving outside WAIT_DONE is ignored.
- host_start outside IDLE is ignored (not queued). host_valid outside COLLECT is ignored.
- Latency: from the last byte handshake, buf_le rises 1 cycle later. buf_start_trans rises 1+len+SETTLE_CYCLES cycles after buf_le.
- Widths: idx and len are 4 bits; the timeout counter is clog2(TIMEOUT_CYCLES) bits and saturates, with no wrap.

Decomposition:
- Package ppm_tx_pkg:
  - state enum (IDLE, COLLECT, LOAD_HDR, LOAD_DATA, SETTLE, TRIGGER, WAIT_DONE, GUARD);
  - LEN_W=4, BYTE_W=8;
  - default MAX_LEN/SETTLE/GUARD/TIMEOUT constants.
- Sub-module ppm_tx_stage_mem: 16x8 register file with one write port (COLLECT) and one combinational read port (LOAD_DATA). The FSM and counters stay in ppm_tx_scheduler.

Test Plan:
- Nominal 4-byte frame:
  - Stimulus: host_start, len=4, bytes C0,AA,DD,AE with no stalls.
  - Response: buf_le=1/buf_n=4 for 1 cycle, then buf_din=C0,AA,DD,AE on 4 consecutive cycles, 3 cycles of 0, one buf_start_trans pulse.
  - With the real frame buffer and shift_two attached: frame_done arrives, tx_done pulses once, busy falls after 4 guard cycles.
- Host stalls: same frame with host_valid low for 5 cycles between AA and DD -> buf_din sequence is still back-to-back with no gap; load starts 1 cycle after the AE handshake.
- Bad length: host_start with len=0 -> tx_err pulse, busy stays 0, buf_le never asserted.
- Timeout: TIMEOUT_CYCLES=20 and buf_frame_done tied low -> tx_err exactly 20 cycles after the WAIT_DONE entry; tx_done never pulses; returns to IDLE after guard.
- Max length plus ignored request:
  - Stimulus: len=15, bytes 01..0F; a second host_start during LOAD_DATA.
  - Response: buf_n=15, 15 Din cycles in order; the second request is ignored and no extra buf_le appears.
- Reset mid-load: assert rst during the 2nd LOAD_DATA cycle -> next edge all buf_* are 0 and busy=0; a subsequent 1-byte frame (len=1, 5A) completes normally.
